reg_bank_write_demux: RTL

- Write side of the register bank: a 1-to-32 demultiplexer plus storage.
- Accepts one 32-bit write per cycle, decodes the 5-bit index to a one-hot enable, and loads the selected register.
- Exposes all register contents on a flat bus, so the 32x1 read multiplexers select from it.
- Sits between the write-back stage and the read-select path of the datapath.

---
 rtl/reg_bank_write_demux_pkg.sv | 12 +
 rtl/reg_bank_write_demux_decoder.sv | 23 ++
 rtl/reg_bank_write_demux.sv | 76 +++++++
 3 files changed

// File: rtl/reg_bank_write_demux_pkg.sv
// Shared constants for the register-bank write side and its read-mux consumers.
// Register k occupies R_FLAT[k*DATA_WIDTH +: DATA_WIDTH] on the flat contents bus.
package reg_bank_write_demux_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INDEX_WIDTH = 5;
    localparam int REG_COUNT   = 2 ** INDEX_WIDTH;
    localparam int COUNT_WIDTH = 16;

    localparam logic [DATA_WIDTH-1:0] RESET_VALUE = '0;

endpackage

// File: rtl/reg_bank_write_demux_decoder.sv
// 5-to-32 one-hot decoder with enable, composed of a 2-to-4 and a 3-to-8 stage.
// The enable gates the high stage, so a disabled decoder outputs zero whatever the select holds.
module decoder_5x32
    import reg_bank_write_demux_pkg::*;
(
    input  logic                   en,
    input  logic [INDEX_WIDTH-1:0] sel,
    output logic [REG_COUNT-1:0]   onehot
);

    logic [3:0] hi_dec;
    logic [7:0] lo_dec;

    assign hi_dec = en ? (4'b0001 << sel[4:3]) : 4'b0000;
    assign lo_dec = 8'b0000_0001 << sel[2:0];

    for (genvar h = 0; h < 4; h++) begin : g_hi
        for (genvar l = 0; l < 8; l++) begin : g_lo
            assign onehot[h*8 + l] = hi_dec[h] & lo_dec[l];
        end
    end

endmodule

// File: rtl/reg_bank_write_demux.sv
// Register-bank write side: decodes one write per cycle into a one-hot enable and
// loads the selected register; all contents are exposed on R_FLAT for the read muxes.
module reg_bank_write_demux
    import reg_bank_write_demux_pkg::*;
#(
    parameter int DATA_W    = DATA_WIDTH,
    parameter int ZERO_REG0 = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          WR_EN,
    input  logic [INDEX_WIDTH-1:0]        WR_ADDR,
    input  logic [DATA_W-1:0]             WR_DATA,
    output logic [REG_COUNT-1:0]          WE_ONEHOT,
    output logic                          WR_ACK,
    output logic [COUNT_WIDTH-1:0]        WR_COUNT,
    output logic [REG_COUNT*DATA_W-1:0]   R_FLAT
);

    // Counter advances modulo 2**COUNT_WIDTH with no saturation.
    function automatic logic [COUNT_WIDTH-1:0] count_inc(input logic [COUNT_WIDTH-1:0] c);
        return c + COUNT_WIDTH'(1);
    endfunction

    logic                   drop_p0;
    logic                   commit_p0;
    logic [REG_COUNT-1:0]   dec_onehot_p0;

    logic [REG_COUNT-1:0]   we_onehot_p1;
    logic                   vld_p1;
    logic [COUNT_WIDTH-1:0] wr_count_p1;

    // Stage p0: qualify the request, then decode; a dropped register-0 write never enables a flop.
    assign drop_p0   = (ZERO_REG0 != 0) && (WR_ADDR == '0);
    assign commit_p0 = WR_EN && !drop_p0;

    decoder_5x32 u_decoder (
        .en     (commit_p0),
        .sel    (WR_ADDR),
        .onehot (dec_onehot_p0)
    );

    // Stage p1: register storage, one enable-qualified flop bank per index.
    for (genvar k = 0; k < REG_COUNT; k++) begin : g_reg
        logic [DATA_W-1:0] q_p1;

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                q_p1 <= DATA_W'(RESET_VALUE);
            end else if (dec_onehot_p0[k]) begin
                q_p1 <= WR_DATA;
            end
        end

        assign R_FLAT[k*DATA_W +: DATA_W] = q_p1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            we_onehot_p1 <= '0;
            vld_p1       <= 1'b0;
            wr_count_p1  <= '0;
        end else begin
            we_onehot_p1 <= dec_onehot_p0;
            vld_p1       <= commit_p0;
            if (commit_p0) begin
                wr_count_p1 <= count_inc(wr_count_p1);
            end
        end
    end

    assign WE_ONEHOT = we_onehot_p1;
    assign WR_ACK    = vld_p1;
    assign WR_COUNT  = wr_count_p1;

endmodule
